// File: rtl/poly_window_eval_if.sv
// poly_window_eval_if: coefficient-in / sample-out bus for poly_window_eval.
//   coef_valid/coef_ready : coefficient set handshake, a0..a3 signed QX.FRAC
//   out_valid/out_ready   : sample stream handshake
//   out_data              : signed 16-bit integer sample
//   out_idx               : x of the current sample
//   out_last              : current sample is x == DATA_SIZE-1
//   sat_flag              : some sample of the current window was clipped
// The master drives coefficients and out_ready; the slave is the evaluator.
interface poly_window_eval_if #(
  parameter int unsigned COEF_W = 32,
  parameter int unsigned IDX_W  = 3
);
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] a0;
  logic [COEF_W-1:0] a1;
  logic [COEF_W-1:0] a2;
  logic [COEF_W-1:0] a3;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              sat_flag;

  modport master (
    output coef_valid, a0, a1, a2, a3, out_ready,
    input  coef_ready, out_valid, out_data, out_idx, out_last, sat_flag
  );

  modport slave (
    input  coef_valid, a0, a1, a2, a3, out_ready,
    output coef_ready, out_valid, out_data, out_idx, out_last, sat_flag
  );
endinterface

// File: rtl/poly_window_eval.sv
// poly_window_eval: takes one cubic coefficient set {a0,a1,a2,a3} and streams
// y(x) = a0 + a1*x + a2*x^2 + a3*x^3 for x = 0..DATA_SIZE-1, one sample per
// accepted beat, using forward differences (adders and shifts only).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : poly_window_eval_if.slave (coef handshake in, sample stream out)
// Configuration macro POLY_SAT_EN: when defined, samples outside the 16-bit
// signed range clamp and raise the sticky sat_flag; otherwise samples wrap
// and sat_flag is tied low.
module poly_window_eval #(
  parameter int unsigned DATA_SIZE = 7,
  parameter int unsigned COEF_W    = 32,
  parameter int unsigned FRAC      = 16,
  parameter int unsigned ACC_W     = 64
) (
  input logic               clk,
  input logic               rst,
  poly_window_eval_if.slave bus
);
  localparam int unsigned IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DATA_SIZE - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StStream = 2'd2;

  localparam logic signed [ACC_W-1:0] Half = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] MaxS = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MinS = ~MaxS;

  function automatic logic signed [ACC_W-1:0] sext(input logic [COEF_W-1:0] v);
    return ACC_W'($signed(v));
  endfunction

  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] y_q, y_d;
  logic signed [ACC_W-1:0] d1_q, d1_d;
  logic signed [ACC_W-1:0] d2_q, d2_d;
  logic signed [ACC_W-1:0] d3_q, d3_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    sat_q, sat_d;

  logic                    streaming;
  logic signed [ACC_W-1:0] r;
  logic [15:0]             sample;
  logic                    sat_now;
  logic                    sat_out;

  assign streaming = (state_q == StStream);
  // Round half up, then arithmetic shift back to integer.
  assign r = (y_q + Half) >>> FRAC;

`ifdef POLY_SAT_EN
  logic clip_hi, clip_lo;
  assign clip_hi = (r > MaxS);
  assign clip_lo = (r < MinS);
  assign sample  = clip_hi ? 16'h7fff : (clip_lo ? 16'h8000 : r[15:0]);
  assign sat_now = clip_hi | clip_lo;
`else
  logic unused_r;
  assign unused_r = ^{r[ACC_W-1:16], MaxS, MinS};
  assign sample   = r[15:0];
  assign sat_now  = 1'b0;
`endif

  // Flag shows the clip on the clipped sample's own valid cycle.
  assign sat_out = sat_q | (streaming & sat_now);

  assign bus.coef_ready = (state_q == StIdle);
  assign bus.out_valid  = streaming;
  assign bus.out_data   = streaming ? sample : 16'h0000;
  assign bus.out_idx    = idx_q;
  assign bus.out_last   = streaming && (idx_q == LastIdx);
  assign bus.sat_flag   = sat_out;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    unique case (state_q)
      StIdle: begin
        // Raw coefficients parked in the difference registers until SETUP.
        if (bus.coef_valid) begin
          y_d     = sext(bus.a0);
          d1_d    = sext(bus.a1);
          d2_d    = sext(bus.a2);
          d3_d    = sext(bus.a3);
          state_d = StSetup;
        end
      end
      StSetup: begin
        d1_d    = d1_q + d2_q + d3_q;
        d2_d    = (d2_q <<< 1) + (d3_q <<< 2) + (d3_q <<< 1);
        d3_d    = (d3_q <<< 2) + (d3_q <<< 1);
        idx_d   = '0;
        sat_d   = 1'b0;
        state_d = StStream;
      end
      StStream: begin
        sat_d = sat_out;
        if (bus.out_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StIdle;
          end else begin
            y_d   = y_q + d1_q;
            d1_d  = d1_q + d2_q;
            d2_d  = d2_q + d3_q;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      y_q     <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: tb/tb_poly_window_eval.sv
// Bench for poly_window_eval: directed spec scenarios plus randomized windows,
// compared against a direct polynomial evaluation of each sample.
module tb_poly_window_eval;
  localparam int N = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  poly_window_eval_if #(.COEF_W(32), .IDX_W(3)) bus ();

  poly_window_eval #(
    .DATA_SIZE(N),
    .COEF_W   (32),
    .FRAC     (16),
    .ACC_W    (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  int got_data[N];
  int got_idx[N];
  bit got_last[N];
  bit got_sat[N];
  int got_n, got_lat, hold_err;
  bit tmo, ready_after, valid_after;

  // Direct evaluation of the rounded integer sample before 16-bit handling.
  function automatic longint model_r(input logic [31:0] c0, c1, c2, c3, input int x);
    longint y;
    longint xl;
    xl = longint'(x);
    y = longint'($signed(c0)) + longint'($signed(c1)) * xl
      + longint'($signed(c2)) * xl * xl + longint'($signed(c3)) * xl * xl * xl;
    return (y + 64'sd32768) >>> 16;
  endfunction

  function automatic int model_data(input logic [31:0] c0, c1, c2, c3, input int x);
    longint r;
    logic [15:0] t;
    r = model_r(c0, c1, c2, c3, x);
`ifdef POLY_SAT_EN
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return int'(r);
`else
    t = r[15:0];
    return int'($signed(t));
`endif
  endfunction

  function automatic bit model_sat(input logic [31:0] c0, c1, c2, c3, input int x);
`ifdef POLY_SAT_EN
    longint r;
    for (int k = 0; k <= x; k++) begin
      r = model_r(c0, c1, c2, c3, k);
      if (r > 32767 || r < -32768) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one window and records what the DUT produced.
  task automatic collect_window(input logic [31:0] c0, c1, c2, c3, input int pct);
    int guard;
    bit done;
    bit p_stall;
    logic [15:0] p_data;
    logic [2:0] p_idx;
    logic p_last, p_sat;
    got_n = 0; got_lat = 0; hold_err = 0; tmo = 0; done = 0;
    bus.a0 = c0; bus.a1 = c1; bus.a2 = c2; bus.a3 = c3;
    bus.coef_valid = 1'b1;
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.coef_ready && guard < 50) begin tick(); guard++; end
    if (!bus.coef_ready) begin tmo = 1; bus.coef_valid = 1'b0; return; end
    tick();
    // Inputs after the handshake must be ignored.
    bus.coef_valid = 1'b0;
    bus.a0 = $urandom(); bus.a1 = $urandom(); bus.a2 = $urandom(); bus.a3 = $urandom();
    got_lat = 1;
    while (!bus.out_valid && got_lat < 20) begin tick(); got_lat++; end
    if (!bus.out_valid) begin tmo = 1; return; end
    p_stall = 0; p_data = '0; p_idx = '0; p_last = 0; p_sat = 0;
    guard = 0;
    while (guard < 500 && !done) begin
      if (p_stall && (bus.out_data !== p_data || bus.out_idx !== p_idx ||
                      bus.out_last !== p_last || bus.sat_flag !== p_sat)) hold_err++;
      bus.out_ready = ($urandom_range(99) < pct);
      p_stall = bus.out_valid && !bus.out_ready;
      p_data = bus.out_data; p_idx = bus.out_idx; p_last = bus.out_last; p_sat = bus.sat_flag;
      if (bus.out_valid && bus.out_ready) begin
        if (got_n < N) begin
          got_data[got_n] = int'($signed(bus.out_data));
          got_idx[got_n]  = int'(bus.out_idx);
          got_last[got_n] = bus.out_last;
          got_sat[got_n]  = bus.sat_flag;
        end
        got_n++;
        done = (bus.out_last === 1'b1) || (got_n > N);
      end
      tick();
      guard++;
    end
    if (!done) tmo = 1;
    ready_after = bus.coef_ready;
    valid_after = bus.out_valid;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    total++; if (bus.coef_ready !== 1'b1) begin bad++; $display("FAIL reset_coef_ready got=%b want=1", bus.coef_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_idx !== 3'd0) begin bad++; $display("FAIL reset_out_idx got=%0d want=0", bus.out_idx); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
    total++; if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat_flag got=%b want=0", bus.sat_flag); end
  endtask

  task automatic test_constant();
    collect_window(32'h0064_0000, 32'h0, 32'h0, 32'h0, 100);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL const_timeout got=%b want=0", tmo); end
    total++; if (got_lat !== 2) begin bad++; $display("FAIL const_latency got=%0d want=2", got_lat); end
    total++; if (got_n !== N) begin bad++; $display("FAIL const_count got=%0d want=%0d", got_n, N); end
    for (int i = 0; i < got_n && i < N; i++) begin
      total++; if (got_data[i] !== 100) begin bad++; $display("FAIL const_data[%0d] got=%0d want=100", i, got_data[i]); end
      total++; if (got_idx[i] !== i) begin bad++; $display("FAIL const_idx[%0d] got=%0d want=%0d", i, got_idx[i], i); end
      total++; if (got_last[i] !== (i == N - 1)) begin bad++; $display("FAIL const_last[%0d] got=%b want=%b", i, got_last[i], i == N - 1); end
    end
  endtask

  task automatic test_cubic();
    int exp_v[N] = '{0, 2, 10, 30, 68, 130, 222};
    collect_window(32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000, 100);
    total++; if (got_n !== N || tmo !== 1'b0) begin bad++; $display("FAIL cubic_count got=%0d want=%0d", got_n, N); end
    for (int i = 0; i < got_n && i < N; i++) begin
      total++; if (got_data[i] !== exp_v[i]) begin bad++; $display("FAIL cubic_data[%0d] got=%0d want=%0d", i, got_data[i], exp_v[i]); end
    end
    total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL cubic_ready_after got=%b want=1", ready_after); end
    total++; if (valid_after !== 1'b0) begin bad++; $display("FAIL cubic_valid_after got=%b want=0", valid_after); end
  endtask

  task automatic test_backpressure();
    int exp_v[N] = '{0, 2, 10, 30, 68, 130, 222};
    collect_window(32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000, 50);
    total++; if (got_n !== N || tmo !== 1'b0) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_n, N); end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL bp_hold got=%0d want=0", hold_err); end
    for (int i = 0; i < got_n && i < N; i++) begin
      total++; if (got_data[i] !== exp_v[i]) begin bad++; $display("FAIL bp_data[%0d] got=%0d want=%0d", i, got_data[i], exp_v[i]); end
      total++; if (got_idx[i] !== i) begin bad++; $display("FAIL bp_idx[%0d] got=%0d want=%0d", i, got_idx[i], i); end
    end
  endtask

  task automatic test_saturation();
    int exp6;
    bit sat6;
`ifdef POLY_SAT_EN
    exp6 = 32767; sat6 = 1'b1;
`else
    exp6 = -22336; sat6 = 1'b0;
`endif
    collect_window(32'h0, 32'h0, 32'h0, 32'h00C8_0000, 100);
    total++; if (got_n !== N || tmo !== 1'b0) begin bad++; $display("FAIL sat_count got=%0d want=%0d", got_n, N); end
    else begin
      total++; if (got_data[5] !== 25000) begin bad++; $display("FAIL sat_data5 got=%0d want=25000", got_data[5]); end
      total++; if (got_sat[5] !== 1'b0) begin bad++; $display("FAIL sat_flag5 got=%b want=0", got_sat[5]); end
      total++; if (got_data[6] !== exp6) begin bad++; $display("FAIL sat_data6 got=%0d want=%0d", got_data[6], exp6); end
      total++; if (got_sat[6] !== sat6) begin bad++; $display("FAIL sat_flag6 got=%b want=%b", got_sat[6], sat6); end
    end
    total++; if (bus.sat_flag !== sat6) begin bad++; $display("FAIL sat_flag_idle got=%b want=%b", bus.sat_flag, sat6); end
  endtask

  task automatic test_rounding();
    collect_window(32'h0000_8000, 32'h0, 32'h0, 32'h0, 100);
    total++; if (got_n !== N) begin bad++; $display("FAIL rnd_up_count got=%0d want=%0d", got_n, N); end
    for (int i = 0; i < got_n && i < N; i++) begin
      total++; if (got_data[i] !== 1) begin bad++; $display("FAIL rnd_up[%0d] got=%0d want=1", i, got_data[i]); end
      total++; if (got_sat[i] !== 1'b0) begin bad++; $display("FAIL rnd_sat_clear[%0d] got=%b want=0", i, got_sat[i]); end
    end
    collect_window(32'hFFFF_8000, 32'h0, 32'h0, 32'h0, 100);
    total++; if (got_n !== N) begin bad++; $display("FAIL rnd_dn_count got=%0d want=%0d", got_n, N); end
    for (int i = 0; i < got_n && i < N; i++) begin
      total++; if (got_data[i] !== 0) begin bad++; $display("FAIL rnd_dn[%0d] got=%0d want=0", i, got_data[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int accepted = 0;
    int guard = 0;
    logic [31:0] c0, c1, c2, c3;
    bus.a0 = 32'h0; bus.a1 = 32'h0001_0000; bus.a2 = 32'h0; bus.a3 = 32'h0001_0000;
    bus.coef_valid = 1'b1;
    while (!bus.coef_ready && guard < 50) begin tick(); guard++; end
    tick();
    bus.coef_valid = 1'b0;
    bus.out_ready = 1'b1;
    guard = 0;
    while (accepted < 4 && guard < 50) begin
      if (bus.out_valid) accepted++;
      tick();
      guard++;
    end
    total++; if (accepted !== 4) begin bad++; $display("FAIL abort_accepted got=%0d want=4", accepted); end
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.coef_ready !== 1'b1) begin bad++; $display("FAIL abort_coef_ready got=%b want=1", bus.coef_ready); end
    total++; if (bus.out_idx !== 3'd0) begin bad++; $display("FAIL abort_out_idx got=%0d want=0", bus.out_idx); end
    total++; if (bus.out_last !== 1'b0) begin bad++; $display("FAIL abort_out_last got=%b want=0", bus.out_last); end
    c0 = 32'h0003_0000; c1 = 32'hFFFF_0000; c2 = 32'h0000_C000; c3 = 32'h0000_4000;
    collect_window(c0, c1, c2, c3, 100);
    total++; if (got_n !== N) begin bad++; $display("FAIL abort_fresh_count got=%0d want=%0d", got_n, N); end
    for (int i = 0; i < got_n && i < N; i++) begin
      total++; if (got_data[i] !== model_data(c0, c1, c2, c3, i)) begin bad++; $display("FAIL abort_fresh[%0d] got=%0d want=%0d", i, got_data[i], model_data(c0, c1, c2, c3, i)); end
      total++; if (got_idx[i] !== i) begin bad++; $display("FAIL abort_fresh_idx[%0d] got=%0d want=%0d", i, got_idx[i], i); end
    end
  endtask

  task automatic test_random();
    logic [31:0] c[4];
    int pct;
    for (int w = 0; w < 8; w++) begin
      for (int k = 0; k < 4; k++) begin
        c[k] = $urandom();
        // Mostly small coefficients so both in-range and clipped samples occur.
        if (w % 4 != 3) c[k] = 32'($signed(c[k]) >>> ($urandom_range(14, 8)));
      end
      pct = $urandom_range(100, 30);
      collect_window(c[0], c[1], c[2], c[3], pct);
      total++; if (got_n !== N || tmo !== 1'b0) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", w, got_n, N); end
      total++; if (hold_err !== 0) begin bad++; $display("FAIL rand%0d_hold got=%0d want=0", w, hold_err); end
      for (int i = 0; i < got_n && i < N; i++) begin
        total++; if (got_data[i] !== model_data(c[0], c[1], c[2], c[3], i)) begin bad++; $display("FAIL rand%0d_data[%0d] got=%0d want=%0d", w, i, got_data[i], model_data(c[0], c[1], c[2], c[3], i)); end
        total++; if (got_sat[i] !== model_sat(c[0], c[1], c[2], c[3], i)) begin bad++; $display("FAIL rand%0d_sat[%0d] got=%b want=%b", w, i, got_sat[i], model_sat(c[0], c[1], c[2], c[3], i)); end
        total++; if (got_last[i] !== (i == N - 1)) begin bad++; $display("FAIL rand%0d_last[%0d] got=%b want=%b", w, i, got_last[i], i == N - 1); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.coef_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a0 = '0; bus.a1 = '0; bus.a2 = '0; bus.a3 = '0;
    test_reset();
    test_constant();
    test_cubic();
    test_backpressure();
    test_saturation();
    test_rounding();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
